pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 64, PC and address width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 64'h80000000, PC value loaded at reset.
REQ-003 SHALL have parameter INST_BYTES, default 4, sequential increment (power of two, 2 or 4).
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, 2..16).
REQ-005 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port stall  input  1  hold PC and RAS.
REQ-008 SHALL have port redirect_valid  input  1  taken branch/jump from execute.
REQ-009 SHALL have port redirect_addr  input  XLEN  redirect target.
REQ-010 SHALL have port trap_valid  input  1  trap/exception redirect.
REQ-011 SHALL have port trap_addr  input  XLEN  trap target.
REQ-012 SHALL have port call_push  input  1  predicted call in current fetch: push pc+INST_BYTES.
REQ-013 SHALL have port ret_pop  input  1  predicted return in current fetch: next PC from RAS top.
REQ-014 SHALL have port fetch_ready  input  1  fetch stage accepts pc.
REQ-015 SHALL have port fetch_valid  output  1  pc is valid for fetch.
REQ-016 SHALL have port pc  output  XLEN  current fetch PC (registered).
REQ-017 SHALL have port pc_seq  output  XLEN  pc + INST_BYTES (combinational).
REQ-018 SHALL have port ras_empty  output  1  RAS holds zero entries.
REQ-019 SHALL have port ras_full  output  1  RAS holds RAS_DEPTH entries.
REQ-020 SHALL have port misalign  output  1  registered one-cycle pulse: accepted target had nonzero low bits.

Function
REQ-021 SHALL implement FSM states BOOT, RUN, BUBBLE; fetch_valid=1 only in RUN.
REQ-022 SHALL go BOOT->RUN on first clock after reset release, unconditionally.
REQ-023 SHALL define fire = fetch_valid & fetch_ready & ~stall.
REQ-024 SHALL select next PC with priority trap_valid > redirect_valid > (fire & ret_pop & ~ras_empty) > fire (pc_seq) > hold.
REQ-025 SHALL accept trap_valid/redirect_valid in every state, regardless of stall or fetch_ready.
REQ-026 SHALL enter BUBBLE for exactly one cycle after an accepted trap or redirect; a further trap/redirect while in BUBBLE is taken and BUBBLE is held one more cycle.
REQ-027 SHALL force the low log2(INST_BYTES) bits of trap/redirect targets to zero and pulse misalign the following cycle if any were set.
REQ-028 SHALL compute pc_seq modulo 2^XLEN (wrap, no carry out).
REQ-029 SHALL sample call_push and ret_pop only on fire; ignored otherwise, including when trap/redirect wins.
REQ-030 SHALL, on ret_pop with ras_empty, fall through to pc_seq and leave the RAS unchanged.
REQ-031 SHALL, on call_push with ras_full, overwrite the oldest entry (circular) and remain full.
REQ-032 SHALL, on simultaneous call_push and ret_pop, use the old top as next PC and replace the top with pc_seq; occupancy unchanged (empty: push only).
REQ-033 SHALL not treat ret_pop as a redirect: no BUBBLE.
REQ-034 SHALL clear RAS occupancy on trap_valid; redirect_valid leaves RAS intact.

Reset
REQ-035 SHALL, while rst=0, hold pc=RESET_VEC, state=BOOT, fetch_valid=0, misalign=0, RAS occupancy 0 (ras_empty=1, ras_full=0), asynchronously.
REQ-036 SHALL, on reset asserted mid-operation, abandon any redirect/bubble/RAS content immediately.

Verification
REQ-037 SHALL cover: release reset, fetch_ready=1 -> cycle1 fetch_valid=0 pc=0x80000000; then pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles.
REQ-038 SHALL cover: pc=0x80000010, stall=1 with redirect_valid, addr 0x80001002 -> next pc=0x80001000, misalign pulse, one cycle fetch_valid=0.
REQ-039 SHALL cover: same cycle trap_valid (0x80000100) and redirect_valid (0x80002000) -> pc=0x80000100, RAS empty.
REQ-040 SHALL cover: five call_push fires at pc 0x100,0x200,0x300,0x400,0x500 (RAS_DEPTH=4) -> four ret_pop fires yield 0x504,0x404,0x304,0x204, then ret_pop falls through to pc_seq.
REQ-041 SHALL cover: XLEN=32, pc=0xFFFFFFFC, fire -> pc=0x00000000.
REQ-042 SHALL cover: rst asserted during BUBBLE -> same-cycle pc=RESET_VEC, fetch_valid=0, ras_empty=1.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with a small circular return-address
// stack. Chooses the next fetch PC from a trap, an execute redirect, a
// predicted return, the sequential address, or a hold.
//
// Handshake: pc is offered to fetch while fetch_valid is high. A fetch is
// consumed ("fire") only on a cycle where fetch_valid & fetch_ready & ~stall.
// call_push and ret_pop describe the fetch being consumed. They are ignored
// on every other cycle. Trap and redirect are not handshaked. They are taken
// on the cycle they are asserted.
module pc_gen #(
  parameter int          XLEN       = 64,
  parameter logic [63:0] RESET_VEC  = 64'h8000_0000,
  parameter int          INST_BYTES = 4,
  parameter int          RAS_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            call_push,
  input  logic            ret_pop,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_seq,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            misalign,
  output logic [1:0]      fsm_state
);

  localparam int OFF_BITS = $clog2(INST_BYTES);
  localparam int PTR_W    = $clog2(RAS_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam logic [XLEN-1:0]  RST_PC   = RESET_VEC[XLEN-1:0];
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t           state;
  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;
  logic [CNT_W-1:0] count;

  logic             fire;
  logic             flush;
  logic             do_push;
  logic             do_ret;
  logic [XLEN-1:0]  tgt_raw;
  logic [XLEN-1:0]  tgt_aligned;
  logic             tgt_misaligned;
  logic [XLEN-1:0]  pc_next;

  assign fsm_state = state;

  // Handshake and RAS request decode. A trap or redirect suppresses any
  // call or return that arrives with the fetch in the same cycle.
  always_comb begin
    fire      = fetch_valid & fetch_ready & ~stall;
    flush     = trap_valid | redirect_valid;
    pc_seq    = pc + XLEN'(INST_BYTES);
    ras_empty = (count == '0);
    ras_full  = (count == FULL_CNT);
    do_push   = fire & ~flush & call_push;
    do_ret    = fire & ~flush & ret_pop & ~ras_empty;
    top_inc   = top + PTR_W'(1);
    top_dec   = top - PTR_W'(1);
  end

  // Redirect target selection and alignment. A trap outranks a redirect.
  // Low offset bits are dropped, and a misaligned target is reported.
  always_comb begin
    tgt_raw        = trap_valid ? trap_addr : redirect_addr;
    tgt_aligned    = {tgt_raw[XLEN-1:OFF_BITS], {OFF_BITS{1'b0}}};
    tgt_misaligned = |tgt_raw[OFF_BITS-1:0];
  end

  // Next-PC priority: trap/redirect, predicted return, sequential, hold.
  always_comb begin
    pc_next = pc;
    if (flush) begin
      pc_next = tgt_aligned;
    end else if (do_ret) begin
      pc_next = ras_mem[top];
    end else if (fire) begin
      pc_next = pc_seq;
    end
  end

  // Control FSM. Any cycle without a trap or redirect goes to RUN.
  // A trap or redirect forces a single BUBBLE cycle, and the bubble is
  // extended if another one arrives while in BUBBLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      fetch_valid <= 1'b0;
      misalign    <= 1'b0;
      pc          <= RST_PC;
    end else begin
      pc       <= pc_next;
      misalign <= flush & tgt_misaligned;
      if (flush) begin
        state       <= BUBBLE;
        fetch_valid <= 1'b0;
      end else begin
        case (state)
          BOOT:    state <= RUN;
          BUBBLE:  state <= RUN;
          RUN:     state <= RUN;
          default: state <= RUN;
        endcase
        fetch_valid <= 1'b1;
      end
    end
  end

  // RAS occupancy and top pointer.
  // A push onto a full stack overwrites the oldest entry.
  // Push and pop together rewrite the top in place.
  // A trap discards the whole stack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top   <= '0;
      count <= '0;
    end else if (trap_valid) begin
      top   <= '0;
      count <= '0;
    end else if (do_push && do_ret) begin
      top   <= top;
      count <= count;
    end else if (do_push) begin
      top   <= top_inc;
      count <= ras_full ? count : count + CNT_W'(1);
    end else if (do_ret) begin
      top   <= top_dec;
      count <= count - CNT_W'(1);
    end
  end

  // RAS storage. Entries are meaningful only below the occupancy count,
  // so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      if (do_ret) begin
        ras_mem[top] <= pc_seq;
      end else begin
        ras_mem[top_inc] <= pc_seq;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed stimulus for pc_gen.
// A reference model holds the PC as a number and the return stack as a
// queue. A compare process checks the 64-bit instance against the model on
// every running cycle. Literal checks pin the model at key points.
// A separate 32-bit instance checks PC wrap-around.
module tb_pc_gen;

  localparam logic [63:0] RV = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_addr;
  logic        trap_valid;
  logic [63:0] trap_addr;
  logic        call_push;
  logic        ret_pop;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [63:0] pc;
  logic [63:0] pc_seq;
  logic        ras_empty;
  logic        ras_full;
  logic        misalign;
  logic [1:0]  fsm_state;

  logic        r32_valid;
  logic [31:0] r32_addr;
  logic        zero = 1'b0;
  logic        one = 1'b1;
  logic [31:0] zero32 = 32'h0;
  logic        fv32;
  logic [31:0] pc32;
  logic [31:0] pc_seq32;
  logic        empty32;
  logic        full32;
  logic        mis32;
  logic [1:0]  state32;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  // reference model state
  logic [63:0] m_pc = RV;
  bit          m_run = 1'b0;
  bit          m_mis = 1'b0;
  logic [63:0] m_ras[$];
  logic [63:0] m_seq;
  bit          m_fire;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(64), .RESET_VEC(RV), .INST_BYTES(4), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .trap_valid(trap_valid), .trap_addr(trap_addr),
    .call_push(call_push), .ret_pop(ret_pop), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .pc(pc), .pc_seq(pc_seq),
    .ras_empty(ras_empty), .ras_full(ras_full), .misalign(misalign),
    .fsm_state(fsm_state)
  );

  pc_gen #(.XLEN(32), .RESET_VEC(RV), .INST_BYTES(4), .RAS_DEPTH(4)) dut32 (
    .clk(clk), .rst(rst), .stall(zero),
    .redirect_valid(r32_valid), .redirect_addr(r32_addr),
    .trap_valid(zero), .trap_addr(zero32),
    .call_push(zero), .ret_pop(zero), .fetch_ready(one),
    .fetch_valid(fv32), .pc(pc32), .pc_seq(pc_seq32),
    .ras_empty(empty32), .ras_full(full32), .misalign(mis32),
    .fsm_state(state32)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: PC arithmetic plus a LIFO queue capped at four entries.
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_pc  = RV;
      m_run = 1'b0;
      m_mis = 1'b0;
      m_ras.delete();
    end else begin
      m_seq  = m_pc + 64'd4;
      m_fire = m_run && fetch_ready && !stall;
      if (trap_valid) begin
        m_pc  = {trap_addr[63:2], 2'b00};
        m_mis = |trap_addr[1:0];
        m_run = 1'b0;
        m_ras.delete();
      end else if (redirect_valid) begin
        m_pc  = {redirect_addr[63:2], 2'b00};
        m_mis = |redirect_addr[1:0];
        m_run = 1'b0;
      end else begin
        m_mis = 1'b0;
        if (m_fire) begin
          if (ret_pop && m_ras.size() > 0) begin
            m_pc = m_ras[$];
            if (call_push) m_ras[m_ras.size()-1] = m_seq;
            else void'(m_ras.pop_back());
          end else begin
            if (call_push) begin
              m_ras.push_back(m_seq);
              if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
            m_pc = m_seq;
          end
        end
        m_run = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (rst && check_en) begin
      chk("pc", pc, m_pc);
      chk("fetch_valid", {63'd0, fetch_valid}, {63'd0, m_run});
      chk("pc_seq", pc_seq, m_pc + 64'd4);
      chk("ras_empty", {63'd0, ras_empty}, {63'd0, m_ras.size() == 0});
      chk("ras_full", {63'd0, ras_full}, {63'd0, m_ras.size() == 4});
      chk("misalign", {63'd0, misalign}, {63'd0, m_mis});
    end
  end

  initial begin
    logic [63:0] ret_exp [5];
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    trap_valid = 1'b0; trap_addr = '0; call_push = 1'b0; ret_pop = 1'b0;
    fetch_ready = 1'b1; r32_valid = 1'b0; r32_addr = '0;

    tick(); tick();
    chk("rst_pc", pc, RV);
    chk("rst_fv", {63'd0, fetch_valid}, 64'd0);
    chk("rst_empty", {63'd0, ras_empty}, 64'd1);
    chk("rst_full", {63'd0, ras_full}, 64'd0);
    chk("rst_mis", {63'd0, misalign}, 64'd0);

    // reset release and sequential fetch
    #2 rst = 1'b1; check_en = 1'b1;
    #1 chk("boot_fv", {63'd0, fetch_valid}, 64'd0);
    chk("boot_pc", pc, 64'h8000_0000);
    tick(); chk("seq0", pc, 64'h8000_0000); chk("seq0_fv", {63'd0, fetch_valid}, 64'd1);
    tick(); chk("seq1", pc, 64'h8000_0004);
    tick(); chk("seq2", pc, 64'h8000_0008);
    tick(); tick(); chk("seq4", pc, 64'h8000_0010);

    // misaligned redirect under stall
    stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 64'h8000_1002;
    tick(); chk("redir_pc", pc, 64'h8000_1000);
    chk("redir_mis", {63'd0, misalign}, 64'd1);
    chk("redir_fv", {63'd0, fetch_valid}, 64'd0);
    stall = 1'b0; redirect_valid = 1'b0;
    tick(); chk("after_bubble_fv", {63'd0, fetch_valid}, 64'd1);
    chk("after_bubble_mis", {63'd0, misalign}, 64'd0);
    chk("after_bubble_pc", pc, 64'h8000_1000);

    // trap beats redirect and clears the stack
    call_push = 1'b1;
    tick(); call_push = 1'b0;
    chk("call_pc", pc, 64'h8000_1004);
    chk("call_nonempty", {63'd0, ras_empty}, 64'd0);
    trap_valid = 1'b1; trap_addr = 64'h8000_0100;
    redirect_valid = 1'b1; redirect_addr = 64'h8000_2000;
    tick(); chk("trap_pc", pc, 64'h8000_0100);
    chk("trap_empty", {63'd0, ras_empty}, 64'd1);
    trap_valid = 1'b0;
    redirect_addr = 64'h8000_0200;
    tick(); chk("bubble_redir_pc", pc, 64'h8000_0200);
    chk("bubble_held_fv", {63'd0, fetch_valid}, 64'd0);
    redirect_valid = 1'b0;
    tick(); chk("bubble_end_fv", {63'd0, fetch_valid}, 64'd1);

    // simultaneous call and return, then return on an empty stack
    call_push = 1'b1;
    tick(); chk("push1_pc", pc, 64'h8000_0204);
    ret_pop = 1'b1;
    tick(); chk("swap_pc", pc, 64'h8000_0204);
    chk("swap_nonempty", {63'd0, ras_empty}, 64'd0);
    call_push = 1'b0;
    tick(); chk("pop_swapped", pc, 64'h8000_0208);
    chk("pop_empty", {63'd0, ras_empty}, 64'd1);
    tick(); chk("pop_fallthru", pc, 64'h8000_020c);
    ret_pop = 1'b0;
    stall = 1'b1; call_push = 1'b1;
    tick(); chk("stall_hold", pc, 64'h8000_020c);
    chk("stall_no_push", {63'd0, ras_empty}, 64'd1);
    stall = 1'b0; call_push = 1'b0;

    // five calls into a four-entry stack, then unwind
    for (int i = 1; i <= 5; i++) begin
      redirect_valid = 1'b1; redirect_addr = 64'(i) * 64'h100;
      tick(); redirect_valid = 1'b0;
      tick(); chk("call_site", pc, 64'(i) * 64'h100);
      call_push = 1'b1;
      tick(); call_push = 1'b0;
    end
    chk("five_full", {63'd0, ras_full}, 64'd1);
    chk("five_pc", pc, 64'h504);
    ret_exp[0] = 64'h504; ret_exp[1] = 64'h404; ret_exp[2] = 64'h304;
    ret_exp[3] = 64'h204; ret_exp[4] = 64'h208;
    ret_pop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); chk("ret_seq", pc, ret_exp[i]);
    end
    ret_pop = 1'b0;

    // reset asserted during a bubble
    call_push = 1'b1;
    tick(); call_push = 1'b0;
    chk("pre_rst_nonempty", {63'd0, ras_empty}, 64'd0);
    redirect_valid = 1'b1; redirect_addr = 64'h40;
    tick(); redirect_valid = 1'b0;
    chk("pre_rst_bubble", {63'd0, fetch_valid}, 64'd0);
    #2 rst = 1'b0;
    #1 chk("mid_rst_pc", pc, RV);
    chk("mid_rst_fv", {63'd0, fetch_valid}, 64'd0);
    chk("mid_rst_empty", {63'd0, ras_empty}, 64'd1);
    chk("mid_rst_mis", {63'd0, misalign}, 64'd0);
    tick(); #2 rst = 1'b1;
    tick(); tick(); chk("post_rst_pc", pc, RV + 64'd4);

    // 32-bit wrap-around
    r32_valid = 1'b1; r32_addr = 32'hFFFF_FFFC;
    tick(); r32_valid = 1'b0;
    chk("w32_pc", {32'd0, pc32}, 64'hFFFF_FFFC);
    chk("w32_seq", {32'd0, pc_seq32}, 64'd0);
    tick(); chk("w32_fv", {63'd0, fv32}, 64'd1);
    tick(); chk("w32_wrap", {32'd0, pc32}, 64'd0);

    check_en = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
